// File: rtl/vga_fb_arbiter_if.sv
// Port bundle of the VGA frame-buffer read arbiter: raster side, CPU read port and frame-memory read port.
// master = arbiter side, slave = surrounding system (raster, CPU, dmem_rom).
interface vga_fb_arbiter_if;
   // CPU handshake: cpu_req is held with cpu_addr stable until cpu_gnt has been
   // seen (a one-cycle pulse); cpu_rvalid pulses exactly one cycle after cpu_gnt,
   // and cpu_rdata holds that data until the next cpu_rvalid.
   logic         frame_start;
   logic         pix_req;
   logic [23:0]  pix_rgb;
   logic         pix_valid;
   logic         underflow;
   logic         cpu_req;
   logic [31:0]  cpu_addr;
   logic         cpu_gnt;
   logic         cpu_rvalid;
   logic [191:0] cpu_rdata;
   logic [31:0]  mem_addr;
   logic         mem_is_vector;
   logic [191:0] mem_rd;

   modport master (
      input  frame_start, pix_req, cpu_req, cpu_addr, mem_rd,
      output pix_rgb, pix_valid, underflow, cpu_gnt, cpu_rvalid, cpu_rdata,
             mem_addr, mem_is_vector
   );

   modport slave (
      output frame_start, pix_req, cpu_req, cpu_addr, mem_rd,
      input  pix_rgb, pix_valid, underflow, cpu_gnt, cpu_rvalid, cpu_rdata,
             mem_addr, mem_is_vector
   );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Scanout scheduler: prefetches image pixels into a small FIFO and shares the read port with a CPU.
// Optional feature macro: VGA_ARB_CPU_EN enables the CPU read port; without it display owns every slot.
module vga_fb_arbiter #(
   parameter int          IMG_W      = 100,
   parameter int          IMG_H      = 100,
   parameter logic [31:0] BASE_ADDR  = 32'h0,
   parameter int          FIFO_DEPTH = 8
) (
   input  logic              clk,
   input  logic              reset,
   vga_fb_arbiter_if.master  bus,
   output logic [1:0]        state_o
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int XW = $clog2(IMG_W + 1);
   localparam int YW = $clog2(IMG_H + 1);
   localparam logic [31:0]   ROW_STRIDE = 32'(3 * IMG_W);
   localparam logic [CW:0]   DEPTH_W    = (CW+1)'(FIFO_DEPTH);
   localparam logic [CW-1:0] HALF_W     = CW'(FIFO_DEPTH / 2);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [XW-1:0] x_q, x_d, x_cur;
   logic [YW-1:0] y_q, y_d, y_cur;
   logic [31:0]   row_base_q, row_base_d, row_base_cur;
   logic [31:0]   col_off_q, col_off_d, col_off_cur;
   logic [31:0]   mem_addr_q, disp_addr, issue_addr;
   logic          rd_v_q, rd_cpu_q;
   logic          underflow_q, underflow_d;
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d, count_cur;
   logic [23:0]   fifo_mem [FIFO_DEPTH];
   logic [23:0]   pix_in;
   logic          fs, push, pop, disp_inflight, disp_elig;
   logic          last_x, last_y, gnt_disp, gnt_cpu;

   // A frame_start cycle already sees the cleared raster/FIFO, so (0,0) can issue at once.
   assign fs           = bus.frame_start;
   assign x_cur        = fs ? '0 : x_q;
   assign y_cur        = fs ? '0 : y_q;
   assign row_base_cur = fs ? '0 : row_base_q;
   assign col_off_cur  = fs ? '0 : col_off_q;
   assign count_cur    = fs ? '0 : count_q;

   assign disp_inflight = rd_v_q && !rd_cpu_q && !fs;
   assign disp_elig     = (fs || state_q == ST_FETCH) &&
                          (({1'b0, count_cur} + (CW+1)'(disp_inflight)) < DEPTH_W);
   assign disp_addr     = BASE_ADDR + row_base_cur + col_off_cur;
   assign last_x        = (x_cur == XW'(IMG_W - 1));
   assign last_y        = (y_cur == YW'(IMG_H - 1));

   assign push   = rd_v_q && !rd_cpu_q && !fs;
   assign pop    = bus.pix_req && (count_q != '0) && !fs;
   assign pix_in = {bus.mem_rd[7:0], bus.mem_rd[39:32], bus.mem_rd[71:64]};

`ifdef VGA_ARB_CPU_EN
   logic         cpu_gnt, cpu_elig, cpu_rvalid_q;
   logic [191:0] cpu_rdata_q;

   assign cpu_gnt    = rd_v_q && rd_cpu_q;
   assign cpu_elig   = bus.cpu_req && !cpu_gnt;
   assign gnt_disp   = disp_elig && (!cpu_elig || (count_cur < HALF_W));
   assign gnt_cpu    = cpu_elig && !gnt_disp;
   assign issue_addr = gnt_cpu ? bus.cpu_addr : disp_addr;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cpu_rvalid_q <= 1'b0;
         cpu_rdata_q  <= '0;
      end else begin
         cpu_rvalid_q <= cpu_gnt;
         if (cpu_gnt) cpu_rdata_q <= bus.mem_rd;
      end
   end

   assign bus.cpu_gnt    = cpu_gnt;
   assign bus.cpu_rvalid = cpu_rvalid_q;
   assign bus.cpu_rdata  = cpu_rdata_q;
`else
   logic unused_cpu;

   assign gnt_disp       = disp_elig;
   assign gnt_cpu        = 1'b0;
   assign issue_addr     = disp_addr;
   assign bus.cpu_gnt    = 1'b0;
   assign bus.cpu_rvalid = 1'b0;
   assign bus.cpu_rdata  = '0;
   assign unused_cpu     = ^{bus.cpu_req, bus.cpu_addr, bus.mem_rd[191:72],
                             bus.mem_rd[63:40], bus.mem_rd[31:8]};
`endif

   always_comb begin
      state_d    = state_q;
      x_d        = x_cur;
      y_d        = y_cur;
      row_base_d = row_base_cur;
      col_off_d  = col_off_cur;
      if (fs) state_d = ST_FETCH;
      if (gnt_disp) begin
         if (last_x) begin
            x_d        = '0;
            col_off_d  = '0;
            y_d        = y_cur + YW'(1);
            row_base_d = row_base_cur + ROW_STRIDE;
            if (last_y) state_d = ST_DONE;
         end else begin
            x_d       = x_cur + XW'(1);
            col_off_d = col_off_cur + 32'd3;
         end
      end
   end

   always_comb begin
      count_d     = count_q;
      underflow_d = underflow_q;
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
      if (fs)                                      underflow_d = 1'b0;
      else if (bus.pix_req && (count_q == '0))     underflow_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         x_q         <= '0;
         y_q         <= '0;
         row_base_q  <= '0;
         col_off_q   <= '0;
         mem_addr_q  <= BASE_ADDR;
         rd_v_q      <= 1'b0;
         rd_cpu_q    <= 1'b0;
         underflow_q <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         row_base_q  <= row_base_d;
         col_off_q   <= col_off_d;
         rd_v_q      <= gnt_disp || gnt_cpu;
         rd_cpu_q    <= gnt_cpu;
         underflow_q <= underflow_d;
         if (gnt_disp || gnt_cpu) mem_addr_q <= issue_addr;
         if (fs) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= pix_in;
   end

   assign bus.pix_valid     = (count_q != '0);
   assign bus.pix_rgb       = (count_q != '0) ? fifo_mem[rd_ptr_q] : 24'h0;
   assign bus.underflow     = underflow_q;
   assign bus.mem_addr      = mem_addr_q;
   assign bus.mem_is_vector = 1'b1;
   assign state_o           = state_q;

endmodule
